// File: rtl/uart_cmd_pkg.sv
// Shared opcodes, FSM encoding and width helper for the UART command parser.
package uart_cmd_pkg;

    localparam logic [7:0] CMD_WRITE = 8'h55;
    localparam logic [7:0] CMD_READ  = 8'hAA;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2
    } state_e;

    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
        int unsigned m;
        m = (a > b) ? a : b;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/frame_timeout.sv
// Idle counter for in-frame byte gaps; flags expiry for one cycle at TIMEOUT_CYC-1.
module frame_timeout #(
    parameter int unsigned TIMEOUT_CYC = 50000
) (
    input  logic sclk,
    input  logic srst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int unsigned W = $clog2(TIMEOUT_CYC);
    localparam logic [W-1:0] LAST = W'(TIMEOUT_CYC - 1);

    logic [W-1:0] cnt_q;

    // A simultaneous clear (incoming byte) suppresses expiry.
    assign expire = en && !clr && (cnt_q == LAST);

    always_ff @(posedge sclk or posedge srst) begin
        if (srst) begin
            cnt_q <= '0;
        end else if (clr || !en || expire) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + W'(1);
        end
    end

endmodule

// File: rtl/uart_cmd_parser.sv
// Parses opcode/address/payload frames from a UART byte stream into FIFO pushes,
// burst triggers and error pulses.
module uart_cmd_parser #(
    parameter int unsigned ADDR_BYTES  = 2,
    parameter int unsigned DATA_BYTES  = 4,
    parameter logic [7:0]  CMD_WRITE   = uart_cmd_pkg::CMD_WRITE,
    parameter logic [7:0]  CMD_READ    = uart_cmd_pkg::CMD_READ,
    parameter int unsigned TIMEOUT_CYC = 50000,
    localparam int unsigned ADDR_W     = 8 * ADDR_BYTES
) (
    input  logic              sclk,
    input  logic              srst,
    input  logic              uart_flag,
    input  logic [7:0]        uart_data,
    output logic              wfifo_wr_en,
    output logic [7:0]        wfifo_data,
    output logic              wr_trig,
    output logic              rd_trig,
    output logic [ADDR_W-1:0] cmd_addr,
    output logic              err_opcode,
    output logic              err_timeout,
    output logic              busy
);

    import uart_cmd_pkg::*;

    localparam int unsigned CNT_W = cnt_width(ADDR_BYTES, DATA_BYTES);
    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_BYTES - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_BYTES - 1);

    state_e            state_q, state_d;
    logic              op_write_q, op_write_d;
    logic [CNT_W-1:0]  byte_cnt_q, byte_cnt_d;
    logic [ADDR_W-1:0] addr_shift_q, addr_shift_d;
    logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
    logic [ADDR_W+7:0] addr_cat;
    logic [ADDR_W-1:0] addr_next;
    logic              wr_en_q, wr_en_d;
    logic [7:0]        wdata_q, wdata_d;
    logic              wr_pend_q, wr_pend_d, wr_trig_q;
    logic              rd_trig_q, rd_trig_d;
    logic              err_op_q, err_op_d;
    logic              err_to_q, err_to_d;
    logic              tmr_en, tmr_clr, expire;

    assign addr_cat  = {addr_shift_q, uart_data};
    assign addr_next = addr_cat[ADDR_W-1:0];
    assign tmr_en    = (state_q != S_IDLE);
    assign tmr_clr   = uart_flag | ~tmr_en;

    frame_timeout #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timeout (
        .sclk  (sclk),
        .srst  (srst),
        .clr   (tmr_clr),
        .en    (tmr_en),
        .expire(expire)
    );

    always_comb begin
        state_d      = state_q;
        op_write_d   = op_write_q;
        byte_cnt_d   = byte_cnt_q;
        addr_shift_d = addr_shift_q;
        cmd_addr_d   = cmd_addr_q;
        wr_en_d      = 1'b0;
        wdata_d      = wdata_q;
        wr_pend_d    = 1'b0;
        rd_trig_d    = 1'b0;
        err_op_d     = 1'b0;
        err_to_d     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (uart_flag) begin
                    if (uart_data == CMD_WRITE || uart_data == CMD_READ) begin
                        state_d    = S_ADDR;
                        byte_cnt_d = '0;
                        op_write_d = (uart_data == CMD_WRITE);
                    end else begin
                        err_op_d = 1'b1;
                    end
                end
            end
            S_ADDR: begin
                if (uart_flag) begin
                    addr_shift_d = addr_next;
                    if (byte_cnt_q == ADDR_LAST) begin
                        byte_cnt_d = '0;
                        if (op_write_q) begin
                            state_d = S_DATA;
                        end else begin
                            state_d    = S_IDLE;
                            cmd_addr_d = addr_next;
                            rd_trig_d  = 1'b1;
                        end
                    end else begin
                        byte_cnt_d = byte_cnt_q + CNT_W'(1);
                    end
                end else if (expire) begin
                    state_d  = S_IDLE;
                    err_to_d = 1'b1;
                end
            end
            S_DATA: begin
                if (uart_flag) begin
                    wr_en_d = 1'b1;
                    wdata_d = uart_data;
                    if (byte_cnt_q == DATA_LAST) begin
                        state_d    = S_IDLE;
                        byte_cnt_d = '0;
                        cmd_addr_d = addr_shift_q;
                        wr_pend_d  = 1'b1;
                    end else begin
                        byte_cnt_d = byte_cnt_q + CNT_W'(1);
                    end
                end else if (expire) begin
                    state_d  = S_IDLE;
                    err_to_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // wr_trig lags the final push by one cycle through wr_pend.
    always_ff @(posedge sclk or posedge srst) begin
        if (srst) begin
            state_q      <= S_IDLE;
            op_write_q   <= 1'b0;
            byte_cnt_q   <= '0;
            addr_shift_q <= '0;
            cmd_addr_q   <= '0;
            wr_en_q      <= 1'b0;
            wdata_q      <= '0;
            wr_pend_q    <= 1'b0;
            wr_trig_q    <= 1'b0;
            rd_trig_q    <= 1'b0;
            err_op_q     <= 1'b0;
            err_to_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_write_q   <= op_write_d;
            byte_cnt_q   <= byte_cnt_d;
            addr_shift_q <= addr_shift_d;
            cmd_addr_q   <= cmd_addr_d;
            wr_en_q      <= wr_en_d;
            wdata_q      <= wdata_d;
            wr_pend_q    <= wr_pend_d;
            wr_trig_q    <= wr_pend_q;
            rd_trig_q    <= rd_trig_d;
            err_op_q     <= err_op_d;
            err_to_q     <= err_to_d;
        end
    end

    assign wfifo_wr_en = wr_en_q;
    assign wfifo_data  = wdata_q;
    assign wr_trig     = wr_trig_q;
    assign rd_trig     = rd_trig_q;
    assign cmd_addr    = cmd_addr_q;
    assign err_opcode  = err_op_q;
    assign err_timeout = err_to_q;
    assign busy        = (state_q != S_IDLE);

endmodule
